// File: rtl/shot_rx_decoder_if.sv
// Shot receive decoder bus: UART RX FIFO side (empty flag, head byte, pop)
// plus the clear input and the decoded shot outputs to the keeper logic.
// The decoder connects through the slave modport; the driver of the FIFO and
// consumer of the shot position uses the master modport.
interface shot_rx_decoder_if;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       i_clr;
  logic       o_rd_uart;
  logic [9:0] o_shot_xpos;
  logic [9:0] o_shot_ypos;
  logic       o_shot_valid;
  logic       o_shot_ready;
  logic       o_frame_err;

  modport slave (
    input  i_rx_empty, i_rx_data, i_clr,
    output o_rd_uart, o_shot_xpos, o_shot_ypos, o_shot_valid, o_shot_ready, o_frame_err
  );

  modport master (
    output i_rx_empty, i_rx_data, i_clr,
    input  o_rd_uart, o_shot_xpos, o_shot_ypos, o_shot_valid, o_shot_ready, o_frame_err
  );
endinterface

// File: rtl/shot_rx_decoder.sv
// Reassembles the 4-byte tagged shot-position stream from the opponent's
// UART RX FIFO into a 10-bit X / 10-bit Y position for the keeper logic.
// Each byte carries a 5-bit payload in [7:3] and a tag in [2:0]; tags must
// arrive in the order 001 (X lo), 010 (X hi), 101 (Y lo), 110 (Y hi).
// Bytes are handled one per three cycles: capture, pop, decode.
// Optional feature macro: SHOT_RX_CLAMP_EN clamps X/Y to X_MAX/Y_MAX on
// frame completion and flags a clamped frame with frame_err.
module shot_rx_decoder #(
  parameter int TIMEOUT_CYCLES = 6501950
`ifdef SHOT_RX_CLAMP_EN
  , parameter logic [9:0] X_MAX = 10'd1023
  , parameter logic [9:0] Y_MAX = 10'd767
`endif
) (
  input logic              clk,
  input logic              rst_n,
  shot_rx_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] TAG_X_LO = 3'b001;
  localparam logic [2:0] TAG_X_HI = 3'b010;
  localparam logic [2:0] TAG_Y_LO = 3'b101;
  localparam logic [2:0] TAG_Y_HI = 3'b110;

  typedef enum logic [1:0] {ST_WAIT, ST_POP, ST_DECODE} state_t;

  state_t           r_state,  w_state_next;
  logic [7:0]       r_byte_q, w_byte_next;
  logic [1:0]       r_idx,    w_idx_next;
  logic [4:0]       r_x_lo,   w_x_lo_next;
  logic [4:0]       r_x_hi,   w_x_hi_next;
  logic [4:0]       r_y_lo,   w_y_lo_next;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next;
  logic [9:0]       r_xpos,   w_xpos_next;
  logic [9:0]       r_ypos,   w_ypos_next;
  logic             r_valid,  w_valid_next;
  logic             r_ready,  w_ready_next;
  logic             r_err,    w_err_next;

  logic [2:0] w_tag;
  logic [4:0] w_payload;
  logic [2:0] w_exp_tag;
  logic [9:0] w_x_full;
  logic [9:0] w_y_full;
`ifdef SHOT_RX_CLAMP_EN
  logic       w_clamp;
`endif

  assign w_tag     = r_byte_q[2:0];
  assign w_payload = r_byte_q[7:3];
  assign w_exp_tag = (r_idx == 2'd0) ? TAG_X_LO :
                     (r_idx == 2'd1) ? TAG_X_HI :
                     (r_idx == 2'd2) ? TAG_Y_LO : TAG_Y_HI;
  assign w_x_full  = {r_x_hi, r_x_lo};
  assign w_y_full  = {w_payload, r_y_lo};

  assign bus.o_rd_uart    = (r_state == ST_POP);
  assign bus.o_shot_xpos  = r_xpos;
  assign bus.o_shot_ypos  = r_ypos;
  assign bus.o_shot_valid = r_valid;
  assign bus.o_shot_ready = r_ready;
  assign bus.o_frame_err  = r_err;

  // State and datapath registers; everything returns to zero/WAIT on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT;
      r_byte_q <= '0;
      r_idx    <= '0;
      r_x_lo   <= '0;
      r_x_hi   <= '0;
      r_y_lo   <= '0;
      r_cnt    <= '0;
      r_xpos   <= '0;
      r_ypos   <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_byte_q <= w_byte_next;
      r_idx    <= w_idx_next;
      r_x_lo   <= w_x_lo_next;
      r_x_hi   <= w_x_hi_next;
      r_y_lo   <= w_y_lo_next;
      r_cnt    <= w_cnt_next;
      r_xpos   <= w_xpos_next;
      r_ypos   <= w_ypos_next;
      r_valid  <= w_valid_next;
      r_ready  <= w_ready_next;
      r_err    <= w_err_next;
    end
  end

  // Next state: inter-byte timeout first, then the byte decode (which wins
  // over a simultaneous timeout), then clear overriding both.
  always_comb begin
    w_state_next = r_state;
    w_byte_next  = r_byte_q;
    w_idx_next   = r_idx;
    w_x_lo_next  = r_x_lo;
    w_x_hi_next  = r_x_hi;
    w_y_lo_next  = r_y_lo;
    w_cnt_next   = r_cnt;
    w_xpos_next  = r_xpos;
    w_ypos_next  = r_ypos;
    w_valid_next = 1'b0;
    w_ready_next = r_ready;
    w_err_next   = 1'b0;
`ifdef SHOT_RX_CLAMP_EN
    w_clamp      = 1'b0;
`endif

    if (r_idx != 2'd0) begin
      if (r_cnt == CNT_LIMIT) begin
        w_idx_next = '0;
        w_cnt_next = '0;
        w_err_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end

    case (r_state)
      ST_WAIT: begin
        if (!bus.i_rx_empty) begin
          w_byte_next  = bus.i_rx_data;
          w_state_next = ST_POP;
        end
      end
      ST_POP: begin
        w_state_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_state_next = ST_WAIT;
        w_cnt_next   = '0;
        w_err_next   = 1'b0;
        if (w_tag == w_exp_tag) begin
          w_idx_next = r_idx + 2'd1;
          case (r_idx)
            2'd0: w_x_lo_next = w_payload;
            2'd1: w_x_hi_next = w_payload;
            2'd2: w_y_lo_next = w_payload;
            default: begin
              w_valid_next = 1'b1;
              w_ready_next = 1'b1;
`ifdef SHOT_RX_CLAMP_EN
              if (w_x_full > X_MAX) begin
                w_xpos_next = X_MAX;
                w_clamp     = 1'b1;
              end else begin
                w_xpos_next = w_x_full;
              end
              if (w_y_full > Y_MAX) begin
                w_ypos_next = Y_MAX;
                w_clamp     = 1'b1;
              end else begin
                w_ypos_next = w_y_full;
              end
              w_err_next = w_clamp;
`else
              w_xpos_next = w_x_full;
              w_ypos_next = w_y_full;
`endif
            end
          endcase
        end else if (w_tag == TAG_X_LO) begin
          w_x_lo_next = w_payload;
          w_idx_next  = 2'd1;
          w_err_next  = (r_idx != 2'd0);
        end else begin
          w_idx_next = '0;
          w_err_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_WAIT;
      end
    endcase

    if (bus.i_clr) begin
      w_idx_next   = '0;
      w_cnt_next   = '0;
      w_x_lo_next  = r_x_lo;
      w_x_hi_next  = r_x_hi;
      w_y_lo_next  = r_y_lo;
      w_xpos_next  = r_xpos;
      w_ypos_next  = r_ypos;
      w_valid_next = 1'b0;
      w_ready_next = 1'b0;
      w_err_next   = 1'b0;
    end
  end

endmodule

// File: doc/shot_rx_decoder.md
Name: shot_rx_decoder

Overview:
- Consumes the 4-byte shot-position stream from the opponent board's UART receive FIFO.
- Reassembles it into a 10-bit X / 10-bit Y shot position and presents it to the keeper-side game logic, which uses it as its shot position input.
- Sits between the UART RX FIFO (show-ahead read data, pop strobe) and the gloves/keeper controller.
- Enforces the byte tag order, resynchronises on corruption and times out stalled frames.

Parameters:
- TIMEOUT_CYCLES, 6501950, max clk cycles allowed between consecutive bytes of one frame (100 ms at 65 MHz).
- X_MAX, 1023, largest legal X (used only with the optional feature).
- Y_MAX, 767, largest legal Y (used only with the optional feature).

Ports:
- clk  in  1  system clock, 65 MHz
- rst  in  1  asynchronous, active-low reset
- rx_empty  in  1  UART RX FIFO empty flag
- rx_data  in  8  UART RX FIFO head byte, valid whenever rx_empty=0
- clr  in  1  synchronous clear: drops any partial frame and clears shot_ready
- rd_uart  out  1  FIFO pop strobe, one-cycle pulse per consumed byte
- shot_xpos  out  10  last complete X position
- shot_ypos  out  10  last complete Y position
- shot_valid  out  1  one-cycle pulse when a new complete frame is latched
- shot_ready  out  1  sticky level; set with shot_valid, cleared by clr
- frame_err  out  1  one-cycle pulse on a discarded byte or frame

Behaviour:
- Byte format: [7:3] is a 5-bit payload, [2:0] is a tag.
- Tags: 001 = X[4:0], 010 = X[9:5], 101 = Y[4:0], 110 = Y[9:5]. Required order is exactly that, idx 0..3.
- Reset (rst=0, async): all outputs 0, FSM in WAIT, idx=0, payload staging regs 0, timeout counter 0.
- FSM states and transitions:
  - WAIT: if rx_empty=0, capture rx_data into byte_q and go to POP; else stay.
  - POP: rd_uart=1 for exactly this one cycle; go to DECODE.
  - DECODE: evaluate byte_q against idx (rules below); go to WAIT.
- Throughput: at most one byte per 3 cycles. rd_uart is never asserted while rx_empty was 1 at capture.
- Decode rules:
  - Tag matches expected idx: store payload into staging, idx+1, timeout counter reset to 0.
  - Matching tag at idx=3: shot_xpos/shot_ypos updated from staging plus this payload on the next edge; shot_valid=1 for one cycle; shot_ready=1; idx=0.
  - Mismatch with tag=001: frame restarts. X[4:0] stored, idx=1, frame_err pulse only if old idx was not 0.
  - Any other mismatch (including unknown tags 000/011/100/111): idx=0, staging unchanged, frame_err pulse.
- Outputs shot_xpos/shot_ypos change only on a complete valid frame. A partial frame never alters them.
- Timeout:
  - Counter increments every cycle while idx≠0 and saturates.
  - When it reaches TIMEOUT_CYCLES: idx=0, counter=0, frame_err pulse.
  - If a timeout and a DECODE occur in the same cycle, DECODE wins (the byte arrived in time).
- clr=1:
  - idx=0, counter=0, shot_ready=0. shot_xpos/shot_ypos are held.
  - If in POP, the pop still completes; if in DECODE, the byte is discarded without frame_err.
  - clr takes priority over a frame completing in the same cycle: no shot_valid, shot_ready=0.
- Reset mid-frame: everything returns to reset values; the byte already in the FIFO is decoded afresh after release.
- Widths: payload concatenation is exact, with no arithmetic. The counter is wide enough for TIMEOUT_CYCLES ($clog2(TIMEOUT_CYCLES+1)).

Optional Feature:
- Macro: SHOT_RX_CLAMP_EN.
- When defined:
  - On frame completion, X > X_MAX is latched as X_MAX and Y > Y_MAX is latched as Y_MAX.
  - frame_err also pulses on a clamped frame; shot_valid still pulses.
- When undefined: raw 10-bit values are latched and no range check is made.

Test Plan:
- Bytes 0x29,0x12,0x5D,0x6E (X=0x051? → X[4:0]=5, X[9:5]=2 → 0x045; Y[4:0]=11, Y[9:5]=13 → 0x1AB) with FIFO non-empty → four rd_uart pulses, shot_valid once, shot_xpos=0x045, shot_ypos=0x1AB, shot_ready=1, frame_err never.
- Bytes 0x29,0x5D (tag 101 out of order) → frame_err pulse, idx=0, no shot_valid, outputs unchanged.
- Bytes 0x29,0x12 then 0x29,0x12,0x5D,0x6E → first partial frame abandoned silently at second 0x29 except one frame_err pulse; final shot_valid with X=0x045, Y=0x1AB.
- Bytes 0x29,0x12 then FIFO empty for TIMEOUT_CYCLES (set 100 in bench) → frame_err at cycle 100, then 0x5D,0x6E → frame_err on 0x5D, no shot_valid.
- Complete frame then clr=1 for one cycle → shot_ready=0, shot_xpos/ypos held; assert rst=0 mid-frame → all outputs 0 immediately, asynchronously.
- With SHOT_RX_CLAMP_EN: frame carrying Y=0x3FF (bytes 0xFD,0xFE for Y) → shot_ypos=767, shot_valid and frame_err both pulse.
